bp_resolve_ctrl: RTL
====================

Name: bp_resolve_ctrl

Overview:
- Sequencing controller for the branch predictor (BTB + 2-bit PHT + tag table) in the pipelined core.
- Tracks every fetched prediction in an in-order in-flight queue from IF to EX.
- At EX resolution it compares the actual next PC against the predicted next PC.
- Drives the predictor's one-cycle training/update port, issues flush plus redirect on mispredict, and keeps saturating statistics counters.

Parameters:
- DEPTH, 4: in-flight queue entries (power of 2, ≥2).
- FLUSH_CYCLES, 2: cycles spent in FLUSH after a mispredict (≥1).
- CNT_W, 32: statistics counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; no push, no pop this cycle
- if_valid  in  1  fetch issued an instruction this cycle
- if_pc  in  32  fetched PC
- if_pred_pc  in  32  predictor's predicted next PC for if_pc
- ex_valid  in  1  oldest in-flight instruction resolves this cycle
- ex_is_cf  in  1  resolving instruction is branch/jump
- ex_taken  in  1  actual taken outcome (ignored if !ex_is_cf)
- ex_target  in  32  actual taken target
- fetch_hold  out  1  queue full; fetch must not issue
- bp_update  out  1  predictor update strobe (predictor's is_control_flow)
- bp_outcome  out  1  predictor training bit (predictor's is_correct) = actual taken
- bp_pc_to_update  out  32  PC being trained
- bp_branch_target  out  32  target written into BTB
- flush  out  1  kill IF/ID/EX-younger instructions
- redirect_valid  out  1  fetch must load redirect_pc
- redirect_pc  out  32  correct next PC
- q_underflow  out  1  sticky: ex_valid seen with empty queue
- branch_count  out  CNT_W  resolved control-flow instructions
- mispredict_count  out  CNT_W  mispredicted instructions

Behaviour:
- Reset:
  - Queue empty, rd/wr pointers 0, state RUN.
  - All outputs 0, counters 0, q_underflow 0.
  - Reset mid-FLUSH returns to RUN immediately.
- Queue:
  - Circular FIFO of {pc, pred_pc}; pointers are log2(DEPTH)+1 bits so full and empty are distinguishable; wrap-around is by natural overflow.
  - fetch_hold = full, combinational.
- Push: state==RUN && if_valid && !stall && (!full || pop this cycle).
- Pop: state==RUN && ex_valid && !stall && !empty.
  - Simultaneous push and pop are legal at any occupancy, including full and empty+push (pop has nothing to take when empty).
- ex_valid && !stall && empty in RUN: no pop, q_underflow<=1 (sticky until reset).
- Resolution (on pop, combinational, head entry):
  - actual_next = (ex_is_cf && ex_taken) ? ex_target : pc+4, modulo 2^32.
  - mispredict = (actual_next != pred_pc). This covers a non-cf instruction predicted taken.
- Update port (registered, asserted the cycle after pop, for exactly 1 cycle):
  - Condition: bp_update = ex_is_cf.
  - bp_pc_to_update = head pc; bp_branch_target = ex_target; bp_outcome = ex_taken.
  - The data outputs hold their last value when bp_update=0.
- Mispredict (registered, cycle after pop):
  - flush=1 and redirect_valid=1 for 1 cycle; redirect_pc = actual_next.
  - The same edge clears the queue (all younger entries are wrong-path), discards any same-cycle push, and sets state to FLUSH with counter=FLUSH_CYCLES-1.
- FLUSH:
  - Pushes, pops and ex_valid are ignored; no underflow check; fetch_hold=0.
  - Decrement each cycle; at 0 → RUN.
  - stall does not extend FLUSH.
- Counters:
  - branch_count increments on each pop with ex_is_cf.
  - mispredict_count increments on each mispredicting pop.
  - Both saturate at all-ones.
- Latency: pop → bp_update/flush/redirect is 1 cycle. No combinational path from ex_* to any output except fetch_hold (queue state only).

Test Plan:
- Reset, then 4 pushes with no pop → fetch_hold=1 after the 4th; a 5th if_valid is not queued; push+pop in the same cycle keeps occupancy at 4.
- Push pc=0x100 with pred_pc=0x104; pop with ex_is_cf=1, ex_taken=0 → next cycle bp_update=1, bp_outcome=0, bp_pc_to_update=0x100, flush=0; branch_count=1.
- Push pc=0x200 with pred_pc=0x204, plus two younger entries; pop with ex_taken=1, ex_target=0x380 → flush=1, redirect_pc=0x380, queue empty, 2 FLUSH cycles ignoring if_valid, mispredict_count=1.
- Non-cf pop (ex_is_cf=0) for pc=0x40 with pred_pc=0x80 → bp_update=0, flush=1, redirect_pc=0x44.
- ex_valid with empty queue in RUN → q_underflow=1 and it stays 1; stall=1 with if_valid/ex_valid → no occupancy change.
- Assert reset during the FLUSH cycle after a mispredict → next cycle state RUN, queue empty, all outputs and counters 0.

Source files
------------

// File: rtl/bp_resolve_ctrl.sv
// Branch predictor resolution controller: in-flight prediction queue,
// EX-stage resolution, predictor training, flush/redirect and statistics.
module bp_resolve_ctrl #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_pred_pc,
  input  logic             ex_valid,
  input  logic             ex_is_cf,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             fetch_hold,
  output logic             bp_update,
  output logic             bp_outcome,
  output logic [31:0]      bp_pc_to_update,
  output logic [31:0]      bp_branch_target,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             q_underflow,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [AW:0]   PTR_ONE    = 1;
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES - 1);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]    state;
  logic [FW-1:0] fcnt;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pred_q [DEPTH];

  logic        run;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        mispredict;
  logic [31:0] head_pc;
  logic [31:0] head_pred;
  logic [31:0] actual_next;

  assign run   = (state == S_RUN);
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign fetch_hold = run && full;

  assign pop  = run && ex_valid && !stall && !empty;
  assign push = run && if_valid && !stall && (!full || pop);

  assign head_pc     = pc_q[rd_ptr[AW-1:0]];
  assign head_pred   = pred_q[rd_ptr[AW-1:0]];
  assign actual_next = (ex_is_cf && ex_taken) ? ex_target
                                              : head_pc + 32'd4;
  // A non-cf instruction predicted taken also lands here.
  assign mispredict  = pop && (actual_next != head_pred);

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr[AW-1:0]]   <= if_pc;
      pred_q[wr_ptr[AW-1:0]] <= if_pred_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_RUN;
      fcnt   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (!run) begin
      if (fcnt == '0) state <= S_RUN;
      else            fcnt  <= fcnt - 1'b1;
    end else if (mispredict) begin
      // Everything younger is wrong-path, including a same-cycle push.
      state  <= S_FLUSH;
      fcnt   <= FLUSH_INIT;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bp_update        <= 1'b0;
      bp_outcome       <= 1'b0;
      bp_pc_to_update  <= '0;
      bp_branch_target <= '0;
      flush            <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      q_underflow      <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      bp_update      <= pop && ex_is_cf;
      flush          <= mispredict;
      redirect_valid <= mispredict;
      if (pop && ex_is_cf) begin
        bp_outcome       <= ex_taken;
        bp_pc_to_update  <= head_pc;
        bp_branch_target <= ex_target;
        if (!(&branch_count))
          branch_count <= branch_count + 1'b1;
      end
      if (mispredict) begin
        redirect_pc <= actual_next;
        if (!(&mispredict_count))
          mispredict_count <= mispredict_count + 1'b1;
      end
      if (run && ex_valid && !stall && empty)
        q_underflow <= 1'b1;
    end
  end

endmodule
